// File: rtl/mc_mem_pkg.sv
// mc_mem_pkg: state encoding, widths and address check shared by mc_mem_responder.
package mc_mem_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES = WORD_W / BYTE_W;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  function automatic logic addr_ok(input logic [WORD_W-1:0] a, input int unsigned mem_bytes);
    return (a[1:0] == 2'b00) && (a <= WORD_W'(mem_bytes - 4));
  endfunction
endpackage

// File: rtl/mc_mem_wait_cnt.sv
// mc_mem_wait_cnt: loadable down-counter with a done flag for wait-state timing.
// Ports: i_clk, i_rst (async, active-high), i_load/i_val load the count,
// i_en decrements toward zero, o_done is high while the count is zero.
module mc_mem_wait_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_en,
  output logic             o_done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_load ? i_val : (i_en && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_done = cnt_q == '0;
endmodule

// File: rtl/mc_mem_responder.sv
// mc_mem_responder: single-outstanding word memory responder with programmable wait states.
// Ports: i_clk, i_rst (async, active-high); request i_req/i_we/i_addr/i_wdata
// (plus i_be lane enables when MC_MEM_BYTEWR_EN is defined); response
// o_rdata/o_ready/o_err and o_busy from acceptance through the response cycle.
// Storage is the big-endian byte array mem (mem[a] holds word bits [31:24]).
module mc_mem_responder
  import mc_mem_pkg::*;
#(
  parameter int MEM_BYTES   = 512,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [WORD_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
`ifdef MC_MEM_BYTEWR_EN
  input  logic [LANES-1:0]  i_be,
`endif
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_ready,
  output logic              o_err,
  output logic              o_busy
);
  localparam int AW = $clog2(MEM_BYTES);
  logic [BYTE_W-1:0] mem [MEM_BYTES];
  state_e state_q, state_d;
  logic we_q, we_d, err_q, err_d;
  logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [LANES-1:0] be_q, be_d, in_be, cur_be;
  logic accept, cnt_done, enter_resp, cur_ok, commit, cur_we;
  logic [WORD_W-1:0] cur_addr, cur_wdata, rd_word;
  logic [AW-1:0] idx;
`ifdef MC_MEM_BYTEWR_EN
  assign in_be = i_be;
`else
  assign in_be = '1;
`endif
  assign accept = state_q == IDLE && i_req;
  // With zero wait states RESP is entered on the accept edge, so the live payload is used.
  assign cur_we = state_q == IDLE ? i_we : we_q;
  assign cur_addr = state_q == IDLE ? i_addr : addr_q;
  assign cur_wdata = state_q == IDLE ? i_wdata : wdata_q;
  assign cur_be = state_q == IDLE ? in_be : be_q;
  assign idx = cur_addr[AW-1:0];
  assign rd_word = {mem[idx], mem[idx + AW'(1)], mem[idx + AW'(2)], mem[idx + AW'(3)]};
  mc_mem_wait_cnt #(.CNT_W(CNT_W)) u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (accept),
    .i_val  (CNT_W'(WAIT_CYCLES - 1)),
    .i_en   (state_q == WAIT),
    .o_done (cnt_done)
  );
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    if (accept) begin
      we_d = i_we;
      addr_d = i_addr;
      wdata_d = i_wdata;
      be_d = in_be;
      state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
    end else if (state_q == WAIT && cnt_done) state_d = RESP;
    else if (state_q == RESP) state_d = IDLE;
    enter_resp = state_d == RESP && state_q != RESP;
    cur_ok = addr_ok(cur_addr, MEM_BYTES);
    commit = enter_resp && cur_ok && cur_we && !i_rst;
    err_d = enter_resp && !cur_ok;
    rdata_d = (enter_resp && cur_ok && !cur_we) ? rd_word : '0;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge i_clk)
    if (commit)
      for (int k = 0; k < LANES; k++)
        if (cur_be[LANES-1-k]) mem[idx + AW'(k)] <= cur_wdata[WORD_W-1-BYTE_W*k -: BYTE_W];
  assign o_ready = state_q == RESP;
  assign o_busy = state_q != IDLE;
  assign o_err = err_q;
  assign o_rdata = rdata_q;
endmodule
